vx_core_rsp_sched: RTL and testbench
====================================

VX_CORE_RSP_SCHED -- requirements
Module: VX_core_rsp_sched

Interface
REQ-001 The module SHALL have parameter NUM_REQS, default 4, meaning core response lanes.
REQ-002 The module SHALL have parameter NUM_BANKS, default 4, meaning bank requesters (>=2).
REQ-003 The module SHALL have parameter WORD_SIZE, default 4, meaning bytes per word; `WORD_WIDTH = 8*WORD_SIZE.
REQ-004 The module SHALL have parameter CORE_TAG_WIDTH, default 8, meaning full core tag width.
REQ-005 The module SHALL have parameter CORE_TAG_ID_BITS, default 2, meaning low tag bits identifying a batch (1..CORE_TAG_WIDTH).
REQ-006 The module SHALL have port clk, input, 1 bit, the single clock.
REQ-007 The module SHALL have port reset, input, 1 bit, reset that is synchronous and active-low (asserted when 0).
REQ-008 The module SHALL have port per_bank_core_rsp_valid, input, NUM_BANKS bits, per-bank response valid.
REQ-009 The module SHALL have port per_bank_core_rsp_tid, input, NUM_BANKS x `REQS_BITS, destination lane.
REQ-010 The module SHALL have port per_bank_core_rsp_tag, input, NUM_BANKS x CORE_TAG_WIDTH, response tag.
REQ-011 The module SHALL have port per_bank_core_rsp_data, input, NUM_BANKS x `WORD_WIDTH, response word.
REQ-012 The module SHALL have port per_bank_core_rsp_ready, output, NUM_BANKS bits, per-bank acceptance.
REQ-013 The module SHALL have outputs core_rsp_valid (1), core_rsp_tmask (NUM_REQS), core_rsp_tag (CORE_TAG_WIDTH) and core_rsp_data (NUM_REQS x `WORD_WIDTH), plus input core_rsp_ready (1).

Function
REQ-014 Leader SHALL be the first valid bank scanning circularly from rr_ptr (rr_ptr, rr_ptr+1, ... mod NUM_BANKS).
REQ-015 Batch SHALL be every valid bank whose tag[CORE_TAG_ID_BITS-1:0] equals the leader's; other banks are excluded.
REQ-016 Two batch banks with equal tid: the one circularly nearer the leader wins; the loser SHALL NOT be acked and competes next cycle.
REQ-017 Capture SHALL occur when any bank is valid and the output register is empty or draining (core_rsp_valid && core_rsp_ready) in that cycle.
REQ-018 On capture, per_bank_core_rsp_ready SHALL be 1 exactly for winning batch banks in that cycle, combinationally; otherwise 0.
REQ-019 On capture the output register SHALL load: valid=1, tmask bit tid set per winner, tag=leader's full tag, data lane=winner's data, unmasked lanes=0.
REQ-020 Latency bank-valid to core_rsp_valid SHALL be exactly 1 cycle when the output register is free.
REQ-021 While core_rsp_valid && !core_rsp_ready, all core_rsp_* outputs SHALL hold stable.
REQ-022 Drain without capture SHALL clear core_rsp_valid next cycle; drain with capture SHALL give back-to-back batches (1 batch/cycle).
REQ-023 On capture rr_ptr SHALL become (leader+1) mod NUM_BANKS; otherwise unchanged.
REQ-024 Wrap-around: leader NUM_BANKS-1 SHALL set rr_ptr to 0.

Reset
REQ-025 While reset==0 at a clk edge, core_rsp_valid, core_rsp_tmask, core_rsp_tag, core_rsp_data and rr_ptr SHALL become 0.
REQ-026 While reset==0, per_bank_core_rsp_ready SHALL be 0 and no capture SHALL occur; a batch held mid-stall is discarded.

Configuration
REQ-027 With macro VX_RSP_SCHED_PERF_EN defined, output perf_stall_cycles (32 bits) SHALL count cycles with core_rsp_valid && !core_rsp_ready, saturating at 2^32-1, reset to 0.
REQ-028 Without VX_RSP_SCHED_PERF_EN, port perf_stall_cycles and its counter SHALL not exist; all other behaviour identical.

Verification (NUM_BANKS=4, NUM_REQS=4, CORE_TAG_ID_BITS=2)
REQ-029 Banks 0,2 valid, tags 0x05,0x09 (id 1), tids 0,3, ready=1 -> both acked; next cycle valid=1, tmask=4'b1001, tag=0x05, rr_ptr=1.
REQ-030 Banks 0,1 valid tags id 1/id 2, rr_ptr=1 -> bank1 leads and alone acked; bank0 follows next cycle; rr_ptr 2 then 1.
REQ-031 Banks 1,2 same tag id, both tid 2, rr_ptr=0 -> bank1 wins (tmask=4'b0100), bank2 acked one cycle later.
REQ-032 core_rsp_ready=0 for 3 cycles with batch held, new bank valid -> outputs stable, no acks, perf_stall_cycles=3 (macro on); capture on drain cycle.
REQ-033 reset=0 asserted during a held batch -> next cycle core_rsp_valid=0, rr_ptr=0, no acks while reset==0.

Source files
------------

// File: rtl/vx_core_rsp_sched_if.sv
// Bank-to-core response bus for vx_core_rsp_sched.
// The bank side drives per_bank_* requests and core_rsp_ready.
// The scheduler side returns per-bank acks and the merged core response.
interface vx_core_rsp_sched_if #(
   parameter int NUM_REQS       = 4,
   parameter int NUM_BANKS      = 4,
   parameter int WORD_SIZE      = 4,
   parameter int CORE_TAG_WIDTH = 8
);
   localparam int REQS_BITS  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
   localparam int WORD_WIDTH = 8 * WORD_SIZE;

   logic [NUM_BANKS-1:0]                     per_bank_core_rsp_valid;
   logic [NUM_BANKS-1:0][REQS_BITS-1:0]      per_bank_core_rsp_tid;
   logic [NUM_BANKS-1:0][CORE_TAG_WIDTH-1:0] per_bank_core_rsp_tag;
   logic [NUM_BANKS-1:0][WORD_WIDTH-1:0]     per_bank_core_rsp_data;
   logic [NUM_BANKS-1:0]                     per_bank_core_rsp_ready;

   logic                                     core_rsp_valid;
   logic [NUM_REQS-1:0]                      core_rsp_tmask;
   logic [CORE_TAG_WIDTH-1:0]                core_rsp_tag;
   logic [NUM_REQS-1:0][WORD_WIDTH-1:0]      core_rsp_data;
   logic                                     core_rsp_ready;

   modport master (
      output per_bank_core_rsp_valid, per_bank_core_rsp_tid, per_bank_core_rsp_tag,
             per_bank_core_rsp_data, core_rsp_ready,
      input  per_bank_core_rsp_ready, core_rsp_valid, core_rsp_tmask, core_rsp_tag,
             core_rsp_data
   );

   modport slave (
      input  per_bank_core_rsp_valid, per_bank_core_rsp_tid, per_bank_core_rsp_tag,
             per_bank_core_rsp_data, core_rsp_ready,
      output per_bank_core_rsp_ready, core_rsp_valid, core_rsp_tmask, core_rsp_tag,
             core_rsp_data
   );
endinterface

// File: rtl/vx_core_rsp_sched.sv
// Core response scheduler: merges per-bank responses that share a batch id
// (low tag bits) into one core response per cycle, round-robin leader pick.
// Optional feature: define VX_RSP_SCHED_PERF_EN to add the perf_stall_cycles
// output (saturating count of cycles stalled by core_rsp_ready).
module vx_core_rsp_sched #(
   parameter int NUM_REQS         = 4,
   parameter int NUM_BANKS        = 4,
   parameter int WORD_SIZE        = 4,
   parameter int CORE_TAG_WIDTH   = 8,
   parameter int CORE_TAG_ID_BITS = 2
) (
   input  logic                clk,
   input  logic                reset,
`ifdef VX_RSP_SCHED_PERF_EN
   output logic [31:0]         perf_stall_cycles,
`endif
   vx_core_rsp_sched_if.slave  rsp
);
   localparam int WORD_WIDTH = 8 * WORD_SIZE;
   localparam int BANK_BITS  = $clog2(NUM_BANKS);
   localparam int PW         = BANK_BITS + 1;

   logic [BANK_BITS-1:0]                rr_ptr;
   logic [BANK_BITS-1:0]                leader;
   logic [BANK_BITS-1:0]                wb;
   logic                                lead_found;
   logic                                any_valid;
   logic                                capture;
   logic [CORE_TAG_ID_BITS-1:0]         lead_id;
   logic [NUM_BANKS-1:0]                batch;
   logic [NUM_BANKS-1:0]                win;
   logic [NUM_REQS-1:0]                 lane_taken;
   logic [NUM_REQS-1:0][WORD_WIDTH-1:0] lane_data;

   logic                                out_valid;
   logic [NUM_REQS-1:0]                 out_tmask;
   logic [CORE_TAG_WIDTH-1:0]           out_tag;
   logic [NUM_REQS-1:0][WORD_WIDTH-1:0] out_data;

   // (base + off) mod NUM_BANKS, with off < NUM_BANKS
   function automatic logic [BANK_BITS-1:0] wrap_add(input logic [BANK_BITS-1:0] base,
                                                     input int off);
      logic [PW-1:0] s;
      s = {1'b0, base} + PW'(off);
      if (s >= PW'(NUM_BANKS)) s = s - PW'(NUM_BANKS);
      return s[BANK_BITS-1:0];
   endfunction

   assign any_valid = |rsp.per_bank_core_rsp_valid;
   assign lead_id   = rsp.per_bank_core_rsp_tag[leader][CORE_TAG_ID_BITS-1:0];

   // leader: first valid bank scanning circularly from rr_ptr
   always_comb begin
      leader     = rr_ptr;
      lead_found = 1'b0;
      for (int i = 0; i < NUM_BANKS; i++) begin
         if (!lead_found && rsp.per_bank_core_rsp_valid[wrap_add(rr_ptr, i)]) begin
            leader     = wrap_add(rr_ptr, i);
            lead_found = 1'b1;
         end
      end
   end

   // batch: valid banks carrying the leader's batch id
   always_comb begin
      batch = '0;
      for (int b = 0; b < NUM_BANKS; b++)
         batch[b] = rsp.per_bank_core_rsp_valid[b] &&
                    (rsp.per_bank_core_rsp_tag[b][CORE_TAG_ID_BITS-1:0] == lead_id);
   end

   // lane arbitration: walking out from the leader, the first bank to claim
   // a lane keeps it; later banks aiming at the same lane retry next cycle
   always_comb begin
      win        = '0;
      lane_taken = '0;
      lane_data  = '0;
      wb         = '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
         wb = wrap_add(leader, i);
         if (batch[wb] && !lane_taken[rsp.per_bank_core_rsp_tid[wb]]) begin
            win[wb]                                = 1'b1;
            lane_taken[rsp.per_bank_core_rsp_tid[wb]] = 1'b1;
            lane_data[rsp.per_bank_core_rsp_tid[wb]]  = rsp.per_bank_core_rsp_data[wb];
         end
      end
   end

   // take a new batch whenever the output slot is empty or being drained
   assign capture = reset && any_valid && (!out_valid || rsp.core_rsp_ready);
   assign rsp.per_bank_core_rsp_ready = capture ? win : '0;

   // output register and round-robin pointer
   always_ff @(posedge clk) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_tmask <= '0;
         out_tag   <= '0;
         out_data  <= '0;
         rr_ptr    <= '0;
      end else if (capture) begin
         out_valid <= 1'b1;
         out_tmask <= lane_taken;
         out_tag   <= rsp.per_bank_core_rsp_tag[leader];
         out_data  <= lane_data;
         rr_ptr    <= wrap_add(leader, 1);
      end else if (rsp.core_rsp_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign rsp.core_rsp_valid = out_valid;
   assign rsp.core_rsp_tmask = out_tmask;
   assign rsp.core_rsp_tag   = out_tag;
   assign rsp.core_rsp_data  = out_data;

`ifdef VX_RSP_SCHED_PERF_EN
   // count cycles the core back-pressures a held response, saturating
   always_ff @(posedge clk) begin
      if (!reset)
         perf_stall_cycles <= '0;
      else if (out_valid && !rsp.core_rsp_ready && (perf_stall_cycles != '1))
         perf_stall_cycles <= perf_stall_cycles + 32'd1;
   end
`endif
endmodule

// File: tb/tb_vx_core_rsp_sched.sv
// Directed bench for vx_core_rsp_sched (4 banks, 4 lanes, 2-bit batch id).
// Expected beats go into a scoreboard when stimulus is driven and are popped
// by a monitor whenever the core accepts a response.
module tb_vx_core_rsp_sched;
   localparam int NR  = 4;
   localparam int NB  = 4;
   localparam int WS  = 4;
   localparam int TW  = 8;
   localparam int IDB = 2;

   typedef struct {
      logic [NR-1:0]    tmask;
      logic [TW-1:0]    tag;
      logic [NR*32-1:0] data;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   vx_core_rsp_sched_if #(.NUM_REQS(NR), .NUM_BANKS(NB), .WORD_SIZE(WS),
                          .CORE_TAG_WIDTH(TW)) bus ();
`ifdef VX_RSP_SCHED_PERF_EN
   logic [31:0] perf_stall_cycles;
`endif

   vx_core_rsp_sched #(.NUM_REQS(NR), .NUM_BANKS(NB), .WORD_SIZE(WS),
                       .CORE_TAG_WIDTH(TW), .CORE_TAG_ID_BITS(IDB)) dut (
      .clk               (clk),
      .reset             (reset),
`ifdef VX_RSP_SCHED_PERF_EN
      .perf_stall_cycles (perf_stall_cycles),
`endif
      .rsp               (bus)
   );

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [NR*32-1:0] mk(input logic [31:0] l0, l1, l2, l3);
      return {l3, l2, l1, l0};
   endfunction

   task automatic push(input logic [NR-1:0] tm, input logic [TW-1:0] tg,
                       input logic [NR*32-1:0] d);
      exp_t e;
      e.tmask = tm;
      e.tag   = tg;
      e.data  = d;
      sb.push_back(e);
   endtask

   task automatic set_bank(input int b, input logic [1:0] tid, input logic [7:0] tag,
                           input logic [31:0] d);
      bus.per_bank_core_rsp_valid[b] = 1'b1;
      bus.per_bank_core_rsp_tid[b]   = tid;
      bus.per_bank_core_rsp_tag[b]   = tag;
      bus.per_bank_core_rsp_data[b]  = d;
   endtask

   task automatic chk_acks(input string name, input logic [NB-1:0] e);
      #1;
      chk(name, bus.per_bank_core_rsp_ready, e);
   endtask

   // one clock; banks that were acked drop their request like a real bank
   task automatic step();
      logic [NB-1:0] acks;
      @(negedge clk);
      acks = bus.per_bank_core_rsp_ready;
      @(posedge clk);
      #1;
      bus.per_bank_core_rsp_valid = bus.per_bank_core_rsp_valid & ~acks;
   endtask

   // monitor: every accepted beat must match the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (reset && bus.core_rsp_valid && bus.core_rsp_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_beat", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("beat_tmask", bus.core_rsp_tmask, e.tmask);
            chk("beat_tag",   bus.core_rsp_tag,   e.tag);
            chk("beat_data",  bus.core_rsp_data,  e.data);
         end
      end
   end

   initial begin
      bus.per_bank_core_rsp_valid = '0;
      bus.per_bank_core_rsp_tid   = '0;
      bus.per_bank_core_rsp_tag   = '0;
      bus.per_bank_core_rsp_data  = '0;
      bus.core_rsp_ready          = 1'b1;

      // reset: no acks even with a bank valid, everything cleared
      set_bank(0, 2'd0, 8'h01, 32'h11);
      @(posedge clk); #1;
      chk_acks("rst_ack", 4'b0000);
      step();
      chk("rst_valid", bus.core_rsp_valid, 0);
      chk("rst_tmask", bus.core_rsp_tmask, 0);
      chk("rst_tag",   bus.core_rsp_tag,   0);
      chk("rst_data",  bus.core_rsp_data,  0);
      chk("rst_rr",    dut.rr_ptr,         0);
`ifdef VX_RSP_SCHED_PERF_EN
      chk("rst_perf",  perf_stall_cycles,  0);
`endif
      bus.per_bank_core_rsp_valid = '0;
      reset = 1'b1;
      step();

      // two banks, same batch id, distinct lanes
      set_bank(0, 2'd0, 8'h05, 32'hA0);
      set_bank(2, 2'd3, 8'h09, 32'hA2);
      push(4'b1001, 8'h05, mk(32'hA0, 0, 0, 32'hA2));
      chk_acks("s1_ack", 4'b0101);
      step();
      chk("s1_valid", bus.core_rsp_valid, 1);
      chk("s1_tmask", bus.core_rsp_tmask, 4'b1001);
      chk("s1_tag",   bus.core_rsp_tag,   8'h05);
      chk("s1_rr",    dut.rr_ptr,         1);
      step();
      chk("s1_drain_valid", bus.core_rsp_valid, 0);

      // different batch ids, rr_ptr=1: bank1 leads, bank0 follows back-to-back
      set_bank(0, 2'd1, 8'h11, 32'hB0);
      set_bank(1, 2'd2, 8'h06, 32'hB1);
      push(4'b0100, 8'h06, mk(0, 0, 32'hB1, 0));
      chk_acks("s2_ack_a", 4'b0010);
      step();
      chk("s2_valid_a", bus.core_rsp_valid, 1);
      chk("s2_tmask_a", bus.core_rsp_tmask, 4'b0100);
      chk("s2_rr_a",    dut.rr_ptr,         2);
      push(4'b0010, 8'h11, mk(0, 32'hB0, 0, 0));
      chk_acks("s2_ack_b", 4'b0001);
      step();
      chk("s2_valid_b", bus.core_rsp_valid, 1);
      chk("s2_tag_b",   bus.core_rsp_tag,   8'h11);
      chk("s2_rr_b",    dut.rr_ptr,         1);
      step();
      chk("s2_drain_valid", bus.core_rsp_valid, 0);

      // leader = last bank wraps rr_ptr to 0
      set_bank(3, 2'd0, 8'h23, 32'hC3);
      push(4'b0001, 8'h23, mk(32'hC3, 0, 0, 0));
      chk_acks("s3_wrap_ack", 4'b1000);
      step();
      chk("s3_wrap_rr", dut.rr_ptr, 0);

      // same batch, same lane: nearer bank wins, loser acked next cycle
      set_bank(1, 2'd2, 8'h02, 32'hD1);
      set_bank(2, 2'd2, 8'h06, 32'hD2);
      push(4'b0100, 8'h02, mk(0, 0, 32'hD1, 0));
      chk_acks("s3_ack_a", 4'b0010);
      step();
      chk("s3_tmask_a", bus.core_rsp_tmask, 4'b0100);
      chk("s3_rr_a",    dut.rr_ptr,         2);
      push(4'b0100, 8'h06, mk(0, 0, 32'hD2, 0));
      chk_acks("s3_ack_b", 4'b0100);
      step();
      chk("s3_tag_b", bus.core_rsp_tag, 8'h06);
      chk("s3_rr_b",  dut.rr_ptr,       3);
      step();
      chk("s3_drain_valid", bus.core_rsp_valid, 0);

      // back-pressure for 3 cycles: outputs hold, no acks, then drain+capture
      bus.core_rsp_ready = 1'b0;
      set_bank(0, 2'd1, 8'h01, 32'hE0);
      push(4'b0010, 8'h01, mk(0, 32'hE0, 0, 0));
      chk_acks("s4_ack_a", 4'b0001);
      step();
      chk("s4_rr_a", dut.rr_ptr, 1);
      set_bank(1, 2'd3, 8'h02, 32'hE1);
      for (int k = 0; k < 3; k++) begin
         chk_acks("s4_stall_ack", 4'b0000);
         step();
         chk("s4_stall_valid", bus.core_rsp_valid, 1);
         chk("s4_stall_tmask", bus.core_rsp_tmask, 4'b0010);
         chk("s4_stall_tag",   bus.core_rsp_tag,   8'h01);
         chk("s4_stall_data",  bus.core_rsp_data,  mk(0, 32'hE0, 0, 0));
      end
`ifdef VX_RSP_SCHED_PERF_EN
      chk("s4_perf", perf_stall_cycles, 3);
`endif
      bus.core_rsp_ready = 1'b1;
      push(4'b1000, 8'h02, mk(0, 0, 0, 32'hE1));
      chk_acks("s4_ack_b", 4'b0010);
      step();
      chk("s4_valid_b", bus.core_rsp_valid, 1);
      chk("s4_tag_b",   bus.core_rsp_tag,   8'h02);
      chk("s4_rr_b",    dut.rr_ptr,         2);
      step();
      chk("s4_drain_valid", bus.core_rsp_valid, 0);
`ifdef VX_RSP_SCHED_PERF_EN
      chk("s4_perf_hold", perf_stall_cycles, 3);
`endif

      // reset while a batch is held: batch discarded, no acks during reset
      bus.core_rsp_ready = 1'b0;
      set_bank(2, 2'd0, 8'h07, 32'hF2);
      chk_acks("s5_ack_a", 4'b0100);
      step();
      chk("s5_valid_a", bus.core_rsp_valid, 1);
      chk("s5_rr_a",    dut.rr_ptr,         3);
      set_bank(0, 2'd1, 8'h04, 32'h60);
      chk_acks("s5_stall_ack", 4'b0000);
      reset = 1'b0;
      chk_acks("s5_rst_ack", 4'b0000);
      step();
      chk("s5_rst_valid", bus.core_rsp_valid, 0);
      chk("s5_rst_tmask", bus.core_rsp_tmask, 0);
      chk("s5_rst_rr",    dut.rr_ptr,         0);
`ifdef VX_RSP_SCHED_PERF_EN
      chk("s5_rst_perf",  perf_stall_cycles,  0);
`endif
      chk_acks("s5_rst_ack2", 4'b0000);
      step();
      reset = 1'b1;
      bus.core_rsp_ready = 1'b1;
      push(4'b0010, 8'h04, mk(0, 32'h60, 0, 0));
      chk_acks("s5_ack_b", 4'b0001);
      step();
      chk("s5_valid_b", bus.core_rsp_valid, 1);
      chk("s5_tag_b",   bus.core_rsp_tag,   8'h04);
      chk("s5_rr_b",    dut.rr_ptr,         1);
      step();
      chk("s5_drain_valid", bus.core_rsp_valid, 0);

      chk("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
